id_scoreboard: RTL and testbench

Parametrised hazard-tracking unit for the decode stage. It replaces the fixed three-stage index-compare hazard check with a per-register pending-write scoreboard. Each architectural register has a countdown of cycles until its new value can be read from the register file. The unit drives the ID stall flag and a stall-cycle statistic, and optionally drives bypass selects for the EX operand muxes.

---
 rtl/id_scoreboard.sv | 139 +++++++++++++
 tb/tb_id_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Decode-stage pending-write scoreboard: per-register countdowns drive ID stall and bypass selects.
// Optional operand bypassing is enabled by defining SCBD_FWD_EN.
module id_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int ALU_LAT  = 3,
  parameter int LOAD_LAT = 4,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid_inst,
  input  logic [IDX_W-1:0]    id_rs1_idx,
  input  logic                id_rs1_used,
  input  logic [IDX_W-1:0]    id_rs2_idx,
  input  logic                id_rs2_used,
  input  logic [IDX_W-1:0]    id_rd_idx,
  input  logic                id_reg_wr,
  input  logic                id_rd_mem,
  input  logic                flush,
  input  logic                pipe_freeze,
  output logic                id_hazard_flag,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [31:0]         stall_cnt,
  output logic [1:0]          fwd_rs1_sel,
  output logic [1:0]          fwd_rs2_sel
);

  localparam logic [CNT_W-1:0] LAT_ALU = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(LOAD_LAT);

  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_REGS-1:0]            w_ld;
  logic [CNT_W-1:0]               w_lat;
  logic [CNT_W-1:0]               w_cnt1;
  logic [CNT_W-1:0]               w_cnt2;
  logic                           w_blk1;
  logic                           w_blk2;
  logic                           w_hz1;
  logic                           w_hz2;
  logic                           w_hazard;
  logic                           w_issue;
  logic [31:0]                    r_stall;

  assign w_cnt[0]    = '0;
  assign w_ld[0]     = 1'b0;
  assign busy_vec[0] = 1'b0;
  assign w_lat       = id_rd_mem ? LAT_LD : LAT_ALU;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [CNT_W-1:0] r_cnt;
    logic             r_ld;
    logic [CNT_W-1:0] w_dec;
    logic             w_hit;

    assign w_dec = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
    assign w_hit = w_issue && (id_rd_idx == IDX_W'(r));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_ld  <= 1'b0;
      end else if (!pipe_freeze) begin
        if (w_hit) begin
          // WAW: never shorten an older, longer countdown
          r_cnt <= (w_dec > w_lat) ? w_dec : w_lat;
          r_ld  <= id_rd_mem;
        end else begin
          r_cnt <= w_dec;
          if (w_dec == '0) r_ld <= 1'b0;
        end
      end
    end

    assign w_cnt[r]    = r_cnt;
    assign w_ld[r]     = r_ld;
    assign busy_vec[r] = (r_cnt != '0);
  end

  assign w_cnt1 = w_cnt[id_rs1_idx];
  assign w_cnt2 = w_cnt[id_rs2_idx];

`ifdef SCBD_FWD_EN
  logic w_ld1;
  logic w_ld2;

  function automatic logic [1:0] f_sel(
    input logic             used,
    input logic [IDX_W-1:0] idx,
    input logic [CNT_W-1:0] cnt,
    input logic             blk
  );
    logic       pend;
    logic [1:0] sel;
    pend = used && (idx != '0) && (cnt != '0) && !blk;
    sel  = 2'd0;
    unique case (1'b1)
      !pend:                         sel = 2'd0;
      pend && (cnt == LAT_ALU):      sel = 2'd1;
      pend && (cnt == LAT_ALU - 1):  sel = 2'd2;
      default:                       sel = 2'd3;
    endcase
    return sel;
  endfunction

  assign w_ld1       = w_ld[id_rs1_idx];
  assign w_ld2       = w_ld[id_rs2_idx];
  assign w_blk1      = w_ld1 && (w_cnt1 >= LAT_ALU);
  assign w_blk2      = w_ld2 && (w_cnt2 >= LAT_ALU);
  assign fwd_rs1_sel = f_sel(id_rs1_used, id_rs1_idx, w_cnt1, w_blk1);
  assign fwd_rs2_sel = f_sel(id_rs2_used, id_rs2_idx, w_cnt2, w_blk2);
`else
  logic w_unused_ld;

  assign w_unused_ld = ^w_ld;
  assign w_blk1      = (w_cnt1 != '0);
  assign w_blk2      = (w_cnt2 != '0);
  assign fwd_rs1_sel = 2'd0;
  assign fwd_rs2_sel = 2'd0;
`endif

  assign w_hz1    = id_rs1_used && (id_rs1_idx != '0) && w_blk1;
  assign w_hz2    = id_rs2_used && (id_rs2_idx != '0) && w_blk2;
  assign w_hazard = id_valid_inst && !flush && (w_hz1 || w_hz2);
  assign w_issue  = id_valid_inst && !flush && !pipe_freeze && !w_hazard
                    && id_reg_wr && (id_rd_idx != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_hazard && !pipe_freeze && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign id_hazard_flag = w_hazard;
  assign stall_cnt      = r_stall;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed testbench for id_scoreboard; expectations follow SCBD_FWD_EN when defined.
module tb_id_scoreboard;

`ifdef SCBD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_inst;
  logic [4:0]  id_rs1_idx;
  logic        id_rs1_used;
  logic [4:0]  id_rs2_idx;
  logic        id_rs2_used;
  logic [4:0]  id_rd_idx;
  logic        id_reg_wr;
  logic        id_rd_mem;
  logic        flush;
  logic        pipe_freeze;
  logic        id_hazard_flag;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;
  logic [1:0]  fwd_rs1_sel;
  logic [1:0]  fwd_rs2_sel;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stall = 32'd0;

  id_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid_inst  (id_valid_inst),
    .id_rs1_idx     (id_rs1_idx),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_idx     (id_rs2_idx),
    .id_rs2_used    (id_rs2_used),
    .id_rd_idx      (id_rd_idx),
    .id_reg_wr      (id_reg_wr),
    .id_rd_mem      (id_rd_mem),
    .flush          (flush),
    .pipe_freeze    (pipe_freeze),
    .id_hazard_flag (id_hazard_flag),
    .busy_vec       (busy_vec),
    .stall_cnt      (stall_cnt),
    .fwd_rs1_sel    (fwd_rs1_sel),
    .fwd_rs2_sel    (fwd_rs2_sel)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wr, input logic mem);
    id_valid_inst = v;
    id_rs1_idx    = rs1;
    id_rs1_used   = u1;
    id_rs2_idx    = rs2;
    id_rs2_used   = u2;
    id_rd_idx     = rd;
    id_reg_wr     = wr;
    id_rd_mem     = mem;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    flush = 1'b0;
    pipe_freeze = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({id_hazard_flag, busy_vec, stall_cnt, fwd_rs1_sel, fwd_rs2_sel} !== '0) begin
      errors++;
      $display("FAIL reset hz=%0b busy=%0h stall=%0d f1=%0d f2=%0d exp all 0",
               id_hazard_flag, busy_vec, stall_cnt, fwd_rs1_sel, fwd_rs2_sel);
    end
  endtask

  task automatic test_alu_stall;
    logic       eh;
    logic [1:0] es;
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      eh = !FWD;
      es = FWD ? ((i == 0) ? 2'd1 : (i == 1) ? 2'd2 : 2'd3) : 2'd0;
      checks++;
      if (id_hazard_flag !== eh || busy_vec[5] !== 1'b1 || fwd_rs1_sel !== es) begin
        errors++;
        $display("FAIL alu_wait%0d hz=%0b busy5=%0b sel=%0d exp hz=%0b busy5=1 sel=%0d",
                 i, id_hazard_flag, busy_vec[5], fwd_rs1_sel, eh, es);
      end
    end
    if (!FWD) exp_stall = exp_stall + 32'd3;
    @(negedge clk);
    #1;
    checks++;
    if (id_hazard_flag !== 1'b0 || busy_vec[5] !== 1'b0 || stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL alu_issue hz=%0b busy5=%0b stall=%0d exp 0 0 %0d",
               id_hazard_flag, busy_vec[5], stall_cnt, exp_stall);
    end
    idle(1);
  endtask

  task automatic test_load_use;
    int         n;
    logic [1:0] es;
    n  = FWD ? 2 : 4;
    es = FWD ? 2'd2 : 2'd0;
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (id_hazard_flag !== 1'b1) begin
        errors++;
        $display("FAIL load_wait%0d hz=%0b exp 1", i, id_hazard_flag);
      end
    end
    exp_stall = exp_stall + 32'(n);
    @(negedge clk);
    #1;
    checks++;
    if (id_hazard_flag !== 1'b0 || fwd_rs1_sel !== es || stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL load_issue hz=%0b sel=%0d stall=%0d exp 0 %0d %0d",
               id_hazard_flag, fwd_rs1_sel, stall_cnt, es, exp_stall);
    end
    idle(4);
  endtask

  task automatic test_x0;
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    #1;
    checks++;
    if (id_hazard_flag !== 1'b0 || busy_vec[0] !== 1'b0 || busy_vec[3] !== 1'b1
        || fwd_rs1_sel !== 2'd0 || fwd_rs2_sel !== 2'd0) begin
      errors++;
      $display("FAIL x0_read hz=%0b b0=%0b b3=%0b f1=%0d f2=%0d exp 0 0 1 0 0",
               id_hazard_flag, busy_vec[0], busy_vec[3], fwd_rs1_sel, fwd_rs2_sel);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      #1;
      checks++;
      if (busy_vec[3] !== (i < 2) || busy_vec[0] !== 1'b0) begin
        errors++;
        $display("FAIL x3_count%0d b3=%0b b0=%0b exp %0b 0",
                 i, busy_vec[3], busy_vec[0], (i < 2));
      end
    end
  endtask

  task automatic test_waw;
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (busy_vec[9] !== (i < 3) || id_hazard_flag !== (!FWD && i < 3)) begin
        errors++;
        $display("FAIL waw%0d b9=%0b hz=%0b exp %0b %0b",
                 i, busy_vec[9], id_hazard_flag, (i < 3), (!FWD && i < 3));
      end
    end
    if (!FWD) exp_stall = exp_stall + 32'd3;
    idle(1);
  endtask

  task automatic test_freeze;
    logic [1:0] es;
    es = FWD ? 2'd2 : 2'd0;
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pipe_freeze = 1'b1;
      drive(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (id_hazard_flag !== !FWD || busy_vec[4] !== 1'b1
          || fwd_rs2_sel !== es || stall_cnt !== exp_stall) begin
        errors++;
        $display("FAIL freeze%0d hz=%0b b4=%0b sel=%0d stall=%0d exp %0b 1 %0d %0d",
                 i, id_hazard_flag, busy_vec[4], fwd_rs2_sel, stall_cnt,
                 !FWD, es, exp_stall);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pipe_freeze = 1'b0;
      #1;
      checks++;
      if (busy_vec[4] !== (i < 2) || id_hazard_flag !== (!FWD && i < 2)) begin
        errors++;
        $display("FAIL thaw%0d b4=%0b hz=%0b exp %0b %0b",
                 i, busy_vec[4], id_hazard_flag, (i < 2), (!FWD && i < 2));
      end
    end
    if (!FWD) exp_stall = exp_stall + 32'd2;
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL freeze_stall got %0d exp %0d", stall_cnt, exp_stall);
    end
    idle(1);
  endtask

  task automatic test_flush_reset;
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    #1;
    checks++;
    if (busy_vec[6] !== 1'b0) begin
      errors++;
      $display("FAIL flush_issue b6=%0b exp 0", busy_vec[6]);
    end
    @(negedge clk);
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (id_hazard_flag !== !FWD || busy_vec[2] !== 1'b1
        || fwd_rs1_sel !== (FWD ? 2'd1 : 2'd0)) begin
      errors++;
      $display("FAIL pre_rst hz=%0b b2=%0b sel=%0d exp %0b 1 %0d",
               id_hazard_flag, busy_vec[2], fwd_rs1_sel, !FWD, (FWD ? 2'd1 : 2'd0));
    end
    flush = 1'b1;
    #1;
    checks++;
    if (id_hazard_flag !== 1'b0) begin
      errors++;
      $display("FAIL flush_hazard hz=%0b exp 0", id_hazard_flag);
    end
    flush = 1'b0;
    rst = 1'b1;
    #1;
    exp_stall = 32'd0;
    checks++;
    if (id_hazard_flag !== 1'b0 || busy_vec !== 32'd0 || stall_cnt !== 32'd0
        || fwd_rs1_sel !== 2'd0) begin
      errors++;
      $display("FAIL async_rst hz=%0b busy=%0h stall=%0d sel=%0d exp all 0",
               id_hazard_flag, busy_vec, stall_cnt, fwd_rs1_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu_stall();
    test_load_use();
    test_x0();
    test_waw();
    test_freeze();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
